// File: rtl/serial_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer, single-entry output holding register.
// Define SERIAL_RX_PARITY_EN to expect an even-parity bit between bit 7 and the stop bit.
module serial_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       busy
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;
`ifdef SERIAL_RX_PARITY_EN
    localparam logic [2:0] S_PARITY    = 3'd5;
`endif

    logic          sync1_q, rx_s_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          oerr_q, oerr_d;
    logic          tick, stop_ok, complete;
`ifdef SERIAL_RX_PARITY_EN
    logic          perr_q, perr_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
        end
    end

    assign tick = (cnt_q == '0);

`ifdef SERIAL_RX_PARITY_EN
    assign stop_ok = rx_s_q && !perr_q;
`else
    assign stop_ok = rx_s_q;
`endif

    // Counter only moves down while nonzero; every sample point reloads it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        ferr_d   = 1'b0;
        complete = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        perr_d   = perr_q;
`endif
        if (state_q != S_IDLE && state_q != S_WAIT_HIGH && !tick)
            cnt_d = cnt_q - 1'b1;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = HALF;
                end
            end
            S_START: begin
                if (tick) begin
                    if (!rx_s_q) begin
                        state_d = S_DATA;
                        cnt_d   = FULL;
                        bit_d   = 3'd0;
`ifdef SERIAL_RX_PARITY_EN
                        perr_d  = 1'b0;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    cnt_d   = FULL;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    perr_d  = ^{shift_q, rx_s_q};
                    cnt_d   = FULL;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (stop_ok) begin
                        complete = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = rx_s_q ? S_IDLE : S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s_q)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A completion coinciding with acceptance replaces the held byte.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        oerr_d  = 1'b0;
        if (complete) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                oerr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
`ifdef SERIAL_RX_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign frame_err   = ferr_q;
    assign overrun_err = oerr_q;
    assign busy        = (state_q != S_IDLE);

endmodule
